// File: rtl/sort_stream4_pkg.sv
// Shared types and constants for the serial four-element sorter.
// Exports the FSM state enum plus element/stage counts and default width.
package sort_stream4_pkg;

    localparam int W_DEF   = 4;
    localparam int N_ELEM  = 4;
    localparam int N_STAGE = 4;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/sort_stream4_if.sv
// Valid/ready stream carrying one W-bit element per transfer.
// master: drives valid/data, samples ready; slave: the reverse.
interface sort_stream4_if
    import sort_stream4_pkg::*;
#(
    parameter int W = W_DEF
) ();

    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/sort_stream4_cmp_swap.sv
// Unsigned compare-exchange: routes the smaller value to lo_out.
// Ports: lo_in/hi_in operands, lo_out/hi_out ordered pair, swapped flag.
module cmp_swap #(
    parameter int W = 4
) (
    input  logic [W-1:0] lo_in,
    input  logic [W-1:0] hi_in,
    output logic [W-1:0] lo_out,
    output logic [W-1:0] hi_out,
    output logic         swapped
);

    // Strict compare so equal values stay put.
    assign swapped = lo_in > hi_in;
    assign lo_out  = swapped ? hi_in : lo_in;
    assign hi_out  = swapped ? lo_in : hi_in;

endmodule

// File: rtl/sort_stream4.sv
// Serial 4-element sorter: load 4 words, odd-even transposition sort
// (one stage per cycle), drain smallest first.
// Ports: clk, rst_n (sync, active-low), in_s (slave stream),
//        out_m (master stream), busy (high while sorting).
module sort_stream4
    import sort_stream4_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    sort_stream4_if.slave   in_s,
    sort_stream4_if.master  out_m,
    output logic            busy
);

    state_e       state_q;
    logic [1:0]   idx_q;
    logic [1:0]   stg_q;
    logic [W-1:0] r_q [N_ELEM];

    logic [W-1:0] a_lo_in, a_hi_in, a_lo, a_hi;
    logic [W-1:0] b_lo, b_hi;
    logic         a_sw, b_sw;

    // Odd stages compare the middle pair, even stages the outer pairs.
    assign a_lo_in = stg_q[0] ? r_q[1] : r_q[0];
    assign a_hi_in = stg_q[0] ? r_q[2] : r_q[1];

    cmp_swap #(.W(W)) u_cs_a (
        .lo_in   (a_lo_in),
        .hi_in   (a_hi_in),
        .lo_out  (a_lo),
        .hi_out  (a_hi),
        .swapped (a_sw)
    );

    cmp_swap #(.W(W)) u_cs_b (
        .lo_in   (r_q[2]),
        .hi_in   (r_q[3]),
        .lo_out  (b_lo),
        .hi_out  (b_hi),
        .swapped (b_sw)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD;
            idx_q   <= 2'd0;
            stg_q   <= 2'd0;
            for (int i = 0; i < N_ELEM; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (in_s.valid) begin
                        r_q[idx_q] <= in_s.data;
                        // idx wraps to 0 after the fourth word
                        idx_q      <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            stg_q   <= 2'd0;
                            state_q <= SORT;
                        end
                    end
                end
                SORT: begin
                    if (stg_q[0]) begin
                        if (a_sw) begin
                            r_q[1] <= a_lo;
                            r_q[2] <= a_hi;
                        end
                    end else begin
                        if (a_sw) begin
                            r_q[0] <= a_lo;
                            r_q[1] <= a_hi;
                        end
                        if (b_sw) begin
                            r_q[2] <= b_lo;
                            r_q[3] <= b_hi;
                        end
                    end
                    stg_q <= stg_q + 2'd1;
                    if (stg_q == 2'(N_STAGE - 1)) begin
                        idx_q   <= 2'd0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_m.ready) begin
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_q <= LOAD;
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign in_s.ready  = (state_q == LOAD);
    assign out_m.valid = (state_q == DRAIN);
    assign out_m.data  = (state_q == DRAIN) ? r_q[idx_q] : '0;
    assign busy        = (state_q == SORT);

endmodule

// File: tb/tb_sort_stream4.sv
// Scoreboard bench for sort_stream4: driver pushes expected words,
// negedge monitor compares every presented output word.
module tb_sort_stream4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    sort_stream4_if #(.W(4)) in_if ();
    sort_stream4_if #(.W(4)) out_if ();

    sort_stream4 #(.W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in_s  (in_if),
        .out_m (out_if),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_acc = 0;
    int first_acc = 0;
    int prev_first = 0;
    logic have_prev = 1'b0;
    logic chk_period = 1'b0;
    logic stall_en = 1'b0;
    logic [3:0] q [$];

    int busy_run = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: compare presented word against scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
            prev_valid = 1'b0;
        end else begin
            if (busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                chk("busy_len", busy_run, 4);
                busy_run = 0;
            end
            if (out_if.valid && !prev_valid)
                chk("latency", cyc - last_acc, 4);
            prev_valid = out_if.valid;
            if (out_if.valid) begin
                if (q.size() == 0) begin
                    chk("extra_word", 1, 0);
                end else begin
                    chk("out_data", int'(out_if.data), int'(q[0]));
                    if (out_if.ready) void'(q.pop_front());
                end
            end
        end
    end

    // Downstream ready: random stalls only when enabled.
    always @(posedge clk) begin
        #1;
        out_if.ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    task automatic push_exp(input logic [3:0] e0, e1, e2, e3);
        q.push_back(e0);
        q.push_back(e1);
        q.push_back(e2);
        q.push_back(e3);
    endtask

    function automatic logic [15:0] ref_sort(input logic [3:0] a, b, c, d);
        logic [3:0] v [4];
        logic [3:0] t;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3 - i; j++)
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        return {v[3], v[2], v[1], v[0]};
    endfunction

    // Called at #1 after a posedge; returns at #1 after accept edge.
    task automatic send_word(input logic [3:0] v, input int gap,
                             input logic first, input logic last);
        int n;
        repeat (gap) begin
            in_if.valid = 1'b0;
            @(posedge clk); #1;
        end
        in_if.valid = 1'b1;
        in_if.data = v;
        n = 0;
        while (!in_if.ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("in_timeout", 1, 0);
        @(posedge clk); #1;
        if (first) first_acc = cyc;
        if (last) begin
            last_acc = cyc;
            in_if.valid = 1'b0;
        end
    endtask

    task automatic send_job(input logic [3:0] a, b, c, d, input int gmax);
        send_word(a, $urandom_range(0, gmax), 1'b1, 1'b0);
        send_word(b, $urandom_range(0, gmax), 1'b0, 1'b0);
        send_word(c, $urandom_range(0, gmax), 1'b0, 1'b0);
        send_word(d, $urandom_range(0, gmax), 1'b0, 1'b1);
        if (chk_period && have_prev)
            chk("period", first_acc - prev_first, 12);
        prev_first = first_acc;
        have_prev = 1'b1;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"}, int'(in_if.ready), 1);
        chk({tag, "_out_valid"}, int'(out_if.valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_out_data"}, int'(out_if.data), 0);
    endtask

    initial begin
        logic [15:0] s;
        logic [3:0] a, b, c, d;
        int n;
        in_if.valid = 1'b0;
        in_if.data = '0;
        out_if.ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_idle("reset");

        // Reverse order, full-rate handshakes.
        push_exp(4'd1, 4'd3, 4'd7, 4'd9);
        send_job(4'd9, 4'd7, 4'd3, 4'd1, 0);
        wait_empty();

        push_exp(4'd2, 4'd2, 4'd5, 4'd5);
        send_job(4'd5, 4'd2, 4'd5, 4'd2, 0);
        wait_empty();

        push_exp(4'd0, 4'd0, 4'd15, 4'd15);
        send_job(4'd15, 4'd0, 4'd15, 4'd0, 0);
        wait_empty();

        // Input gaps and output stalls.
        stall_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_exp(4'd0, 4'd4, 4'd8, 4'd12);
            send_job(4'd4, 4'd12, 4'd8, 4'd0, 3);
        end
        wait_empty();
        stall_en = 1'b0;
        @(posedge clk); #1;

        // Reset while the sort is at stage 2.
        send_job(4'd8, 4'd6, 4'd4, 4'd2, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_idle("rst_sort");
        push_exp(4'd1, 4'd3, 4'd6, 4'd9);
        send_job(4'd6, 4'd3, 4'd9, 4'd1, 0);
        wait_empty();

        // Reset after the second drain transfer.
        push_exp(4'd2, 4'd5, 4'd10, 4'd14);
        send_job(4'd14, 4'd2, 4'd10, 4'd5, 0);
        n = 0;
        while (q.size() != 2 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("mid_drain_reach", q.size(), 2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete();
        chk("rst_drain_in_ready", int'(in_if.ready), 1);
        chk("rst_drain_out_valid", int'(out_if.valid), 0);
        push_exp(4'd1, 4'd3, 4'd6, 4'd9);
        send_job(4'd6, 4'd3, 4'd9, 4'd1, 0);
        wait_empty();

        // Back-to-back random jobs at full rate.
        have_prev = 1'b0;
        chk_period = 1'b1;
        for (int k = 0; k < 100; k++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            c = 4'($urandom_range(0, 15));
            d = 4'($urandom_range(0, 15));
            s = ref_sort(a, b, c, d);
            push_exp(s[3:0], s[7:4], s[11:8], s[15:12]);
            send_job(a, b, c, d, 0);
        end
        chk_period = 1'b0;
        wait_empty();
        repeat (5) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
